// File: rtl/ibex_data_sram_bridge.sv
// Ibex data port (req/gnt/rvalid) to sky130 1rw1r SRAM port 0 bridge with address-window decode.
// Grant after WAIT_STATES cycles, response one cycle after grant; responses are never stalled.
module ibex_data_sram_bridge #(
    parameter int          ADDR_WIDTH  = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  data_req_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [31:0]           data_addr_i,
    input  logic [31:0]           data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic                  data_err_o,
    output logic [31:0]           data_rdata_o,
    output logic                  sram_csb0_o,
    output logic                  sram_web0_o,
    output logic [3:0]            sram_wmask0_o,
    output logic [ADDR_WIDTH-1:0] sram_addr0_o,
    output logic [31:0]           sram_din0_o,
    input  logic [31:0]           sram_dout0_i
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;
    localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    logic [0:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       gnt_raw;
    logic       gnt;
    logic       hit;
    logic       access;
    logic       rvalid_q, rwe_q, rerr_q;
    logic       unused_addr_lsbs;

    assign hit = (data_addr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign unused_addr_lsbs = ^data_addr_i[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_raw = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (data_req_i) begin
                    if (WAIT_STATES == 0) begin
                        gnt_raw = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                // A withdrawn request is abandoned silently; no response is owed.
                if (!data_req_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 3'd0) begin
                    gnt_raw = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Gate with reset so a request held during reset cannot produce a grant or SRAM access.
    assign gnt    = gnt_raw & resetn;
    assign access = gnt & hit;

    assign data_gnt_o    = gnt;
    assign sram_csb0_o   = ~access;
    assign sram_web0_o   = ~(access & data_we_i);
    assign sram_wmask0_o = (access && data_we_i) ? data_be_i : 4'h0;
    assign sram_addr0_o  = access ? data_addr_i[ADDR_WIDTH+1:2] : '0;
    assign sram_din0_o   = access ? data_wdata_i : 32'h0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            rvalid_q <= 1'b0;
            rwe_q    <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= gnt;
            rwe_q    <= gnt & data_we_i;
            rerr_q   <= gnt & ~hit;
        end
    end

    assign data_rvalid_o = rvalid_q;
    assign data_err_o    = rvalid_q & rerr_q;
    assign data_rdata_o  = (rvalid_q && !rwe_q && !rerr_q) ? sram_dout0_i : 32'h0;

endmodule

// File: tb/tb_ibex_data_sram_bridge.sv
// Directed bench: a zero-wait-state bridge and a two-wait-state bridge, each with a behavioural SRAM.
module tb_ibex_data_sram_bridge;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // W=0 instance
    logic        req0 = 1'b0, we0 = 1'b0;
    logic [3:0]  be0 = 4'h0;
    logic [31:0] addr0 = '0, wd0 = '0;
    logic        gnt0, rv0, err0, csb0, web0;
    logic [31:0] rd0, sd0, dout0;
    logic [3:0]  wm0;
    logic [7:0]  sa0;
    logic [31:0] mem0 [0:255];

    ibex_data_sram_bridge #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
        .clk(clk), .resetn(resetn),
        .data_req_i(req0), .data_we_i(we0), .data_be_i(be0), .data_addr_i(addr0), .data_wdata_i(wd0),
        .data_gnt_o(gnt0), .data_rvalid_o(rv0), .data_err_o(err0), .data_rdata_o(rd0),
        .sram_csb0_o(csb0), .sram_web0_o(web0), .sram_wmask0_o(wm0), .sram_addr0_o(sa0),
        .sram_din0_o(sd0), .sram_dout0_i(dout0)
    );

    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) begin
                for (int b = 0; b < 4; b++)
                    if (wm0[b]) mem0[sa0][8*b +: 8] <= sd0[8*b +: 8];
            end else begin
                dout0 <= mem0[sa0];
            end
        end
    end

    // W=2 instance
    logic        req2 = 1'b0;
    logic [31:0] addr2 = '0;
    logic        gnt2, rv2, err2, csb2, web2;
    logic [31:0] rd2, sd2, dout2;
    logic [3:0]  wm2;
    logic [7:0]  sa2;
    logic [31:0] mem2 [0:255];

    ibex_data_sram_bridge #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0), .WAIT_STATES(2)) dut2 (
        .clk(clk), .resetn(resetn),
        .data_req_i(req2), .data_we_i(1'b0), .data_be_i(4'hF), .data_addr_i(addr2), .data_wdata_i(32'h0),
        .data_gnt_o(gnt2), .data_rvalid_o(rv2), .data_err_o(err2), .data_rdata_o(rd2),
        .sram_csb0_o(csb2), .sram_web0_o(web2), .sram_wmask0_o(wm2), .sram_addr0_o(sa2),
        .sram_din0_o(sd2), .sram_dout0_i(dout2)
    );

    always @(posedge clk) begin
        if (!csb2 && web2) dout2 <= mem2[sa2];
    end

    logic [31:0] b2b_exp [0:3];

    initial begin
        dout0 = 32'h5555_5555;
        dout2 = 32'h5555_5555;
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 32'h0;
            mem2[i] = 32'h0;
        end
        mem0[5] = 32'hDEAD_BEEF;
        b2b_exp[0] = 32'hA000_0001; b2b_exp[1] = 32'hB000_0002;
        b2b_exp[2] = 32'hC000_0003; b2b_exp[3] = 32'hD000_0004;
        for (int i = 0; i < 4; i++) mem0[i] = b2b_exp[i];
        mem2[2] = 32'h1234_5678;
        mem2[3] = 32'hCAFE_F00D;

        // Reset values
        #23;
        check_val("rst_gnt", {31'b0, gnt0}, 32'h0);
        check_val("rst_rvalid", {31'b0, rv0}, 32'h0);
        check_val("rst_err", {31'b0, err0}, 32'h0);
        check_val("rst_rdata", rd0, 32'h0);
        check_val("rst_csb", {31'b0, csb0}, 32'h1);
        check_val("rst_web", {31'b0, web0}, 32'h1);
        check_val("rst_wmask", {28'b0, wm0}, 32'h0);
        check_val("rst_addr", {24'b0, sa0}, 32'h0);
        check_val("rst_din", sd0, 32'h0);
        check_val("rst_rvalid_w2", {31'b0, rv2}, 32'h0);
        resetn = 1'b1;

        // Hit read, W=0
        next_cycle();
        req0 = 1'b1; we0 = 1'b0; be0 = 4'hF; addr0 = 32'h14; #4;
        check_val("rd_gnt", {31'b0, gnt0}, 32'h1);
        check_val("rd_csb", {31'b0, csb0}, 32'h0);
        check_val("rd_web", {31'b0, web0}, 32'h1);
        check_val("rd_wmask", {28'b0, wm0}, 32'h0);
        check_val("rd_addr", {24'b0, sa0}, 32'h5);
        next_cycle();
        req0 = 1'b0; #4;
        check_val("rd_rvalid", {31'b0, rv0}, 32'h1);
        check_val("rd_err", {31'b0, err0}, 32'h0);
        check_val("rd_rdata", rd0, 32'hDEAD_BEEF);
        check_val("rd_gnt_idle", {31'b0, gnt0}, 32'h0);
        check_val("rd_csb_idle", {31'b0, csb0}, 32'h1);
        next_cycle(); #4;
        check_val("rd_rvalid_one", {31'b0, rv0}, 32'h0);

        // Byte-masked writes then read-back
        next_cycle();
        req0 = 1'b1; we0 = 1'b1; be0 = 4'hF; addr0 = 32'h20; wd0 = 32'h1122_3344; #4;
        check_val("wr1_gnt", {31'b0, gnt0}, 32'h1);
        check_val("wr1_web", {31'b0, web0}, 32'h0);
        check_val("wr1_wmask", {28'b0, wm0}, 32'hF);
        check_val("wr1_addr", {24'b0, sa0}, 32'h8);
        check_val("wr1_din", sd0, 32'h1122_3344);
        next_cycle();
        be0 = 4'b1001; wd0 = 32'hAA00_00BB; #4;
        check_val("wr2_gnt", {31'b0, gnt0}, 32'h1);
        check_val("wr2_wmask", {28'b0, wm0}, 32'h9);
        check_val("wr1_rvalid", {31'b0, rv0}, 32'h1);
        check_val("wr1_err", {31'b0, err0}, 32'h0);
        check_val("wr1_rdata", rd0, 32'h0);
        next_cycle();
        we0 = 1'b0; be0 = 4'hF; wd0 = 32'h0; #4;
        check_val("rb_web", {31'b0, web0}, 32'h1);
        check_val("wr2_rvalid", {31'b0, rv0}, 32'h1);
        check_val("wr2_rdata", rd0, 32'h0);
        next_cycle();
        req0 = 1'b0; #4;
        check_val("rb_rvalid", {31'b0, rv0}, 32'h1);
        check_val("rb_rdata", rd0, 32'hAA22_33BB);

        // Out of window
        next_cycle();
        req0 = 1'b1; addr0 = 32'h400; #4;
        check_val("oow_gnt", {31'b0, gnt0}, 32'h1);
        check_val("oow_csb", {31'b0, csb0}, 32'h1);
        check_val("oow_addr", {24'b0, sa0}, 32'h0);
        next_cycle();
        req0 = 1'b0; #4;
        check_val("oow_rvalid", {31'b0, rv0}, 32'h1);
        check_val("oow_err", {31'b0, err0}, 32'h1);
        check_val("oow_rdata", rd0, 32'h0);

        // Back-to-back reads, W=0
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            req0 = (i < 4); addr0 = 32'(4 * i); #4;
            check_val($sformatf("b2b_gnt%0d", i), {31'b0, gnt0}, (i < 4) ? 32'h1 : 32'h0);
            if (i < 4) check_val($sformatf("b2b_addr%0d", i), {24'b0, sa0}, 32'(i));
            check_val($sformatf("b2b_rvalid%0d", i), {31'b0, rv0}, (i > 0) ? 32'h1 : 32'h0);
            if (i > 0) check_val($sformatf("b2b_rdata%0d", i - 1), rd0, b2b_exp[i - 1]);
        end
        addr0 = 32'h0;

        // Wait states, W=2: two accesses with request held
        next_cycle();
        req2 = 1'b1; addr2 = 32'h8; #4;
        check_val("w2_c0_gnt", {31'b0, gnt2}, 32'h0);
        check_val("w2_c0_csb", {31'b0, csb2}, 32'h1);
        next_cycle(); #4;
        check_val("w2_c1_gnt", {31'b0, gnt2}, 32'h0);
        next_cycle(); #4;
        check_val("w2_c2_gnt", {31'b0, gnt2}, 32'h1);
        check_val("w2_c2_addr", {24'b0, sa2}, 32'h2);
        check_val("w2_c2_rvalid", {31'b0, rv2}, 32'h0);
        next_cycle();
        addr2 = 32'hC; #4;
        check_val("w2_c3_gnt", {31'b0, gnt2}, 32'h0);
        check_val("w2_c3_rvalid", {31'b0, rv2}, 32'h1);
        check_val("w2_c3_rdata", rd2, 32'h1234_5678);
        check_val("w2_c3_err", {31'b0, err2}, 32'h0);
        next_cycle(); #4;
        check_val("w2_c4_gnt", {31'b0, gnt2}, 32'h0);
        check_val("w2_c4_rvalid", {31'b0, rv2}, 32'h0);
        next_cycle(); #4;
        check_val("w2_c5_gnt", {31'b0, gnt2}, 32'h1);
        check_val("w2_c5_addr", {24'b0, sa2}, 32'h3);
        next_cycle();
        req2 = 1'b0; #4;
        check_val("w2_c6_gnt", {31'b0, gnt2}, 32'h0);
        check_val("w2_c6_rvalid", {31'b0, rv2}, 32'h1);
        check_val("w2_c6_rdata", rd2, 32'hCAFE_F00D);

        // W=2: request withdrawn in cycle 1, then a fresh request
        next_cycle();
        req2 = 1'b1; addr2 = 32'h8; #4;
        check_val("drop_c0_gnt", {31'b0, gnt2}, 32'h0);
        next_cycle();
        req2 = 1'b0; #4;
        check_val("drop_c1_gnt", {31'b0, gnt2}, 32'h0);
        next_cycle(); #4;
        check_val("drop_c2_gnt", {31'b0, gnt2}, 32'h0);
        check_val("drop_c2_rvalid", {31'b0, rv2}, 32'h0);
        next_cycle();
        req2 = 1'b1; #4;
        check_val("drop_c3_gnt", {31'b0, gnt2}, 32'h0);
        check_val("drop_c3_rvalid", {31'b0, rv2}, 32'h0);
        next_cycle(); #4;
        check_val("drop_c4_gnt", {31'b0, gnt2}, 32'h0);
        next_cycle(); #4;
        check_val("drop_c5_gnt", {31'b0, gnt2}, 32'h1);
        next_cycle();
        req2 = 1'b0; #4;
        check_val("drop_c6_rvalid", {31'b0, rv2}, 32'h1);
        check_val("drop_c6_rdata", rd2, 32'h1234_5678);

        // Reset asserted the cycle after a grant
        next_cycle();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h14; #4;
        check_val("mr_gnt", {31'b0, gnt0}, 32'h1);
        next_cycle();
        resetn = 1'b0; #1;
        check_val("mr_rvalid", {31'b0, rv0}, 32'h0);
        check_val("mr_csb", {31'b0, csb0}, 32'h1);
        check_val("mr_gnt_held_req", {31'b0, gnt0}, 32'h0);
        check_val("mr_rdata", rd0, 32'h0);
        next_cycle(); #4;
        check_val("mr_rvalid_hold", {31'b0, rv0}, 32'h0);
        req0 = 1'b0;
        resetn = 1'b1;
        next_cycle(); #4;
        check_val("mr_post_rvalid", {31'b0, rv0}, 32'h0);
        next_cycle();
        req0 = 1'b1; addr0 = 32'h14; #4;
        check_val("mr_new_gnt", {31'b0, gnt0}, 32'h1);
        next_cycle();
        req0 = 1'b0; #4;
        check_val("mr_new_rvalid", {31'b0, rv0}, 32'h1);
        check_val("mr_new_rdata", rd0, 32'hDEAD_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ibex_data_sram_bridge.md
# ibex_data_sram_bridge

Protocol bridge between the Ibex core data port (req/gnt/rvalid) and the 1 KB single-port-used `sram_1rw1r_32_256_8_sky130` data memory on port 0. It generates the grant and response handshakes the core expects, decodes the SRAM address window, returns a bus error for accesses outside it, and optionally inserts wait states before grant. It sits between the core's data interface and the SRAM macro in the SoC top.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: SRAM word-address width; window size is 4·2^ADDR_WIDTH bytes.
- `BASE_ADDR`, 32'h0000_0000: window base; must be aligned to window size.
- `WAIT_STATES`, 0: cycles inserted between request and grant (0..7).

Ports:
- `clk` in 1: single clock; the SRAM macro samples on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `data_req_i` in 1: core request.
- `data_we_i` in 1: 1 = write.
- `data_be_i` in 4: byte enables.
- `data_addr_i` in 32: byte address.
- `data_wdata_i` in 32: write data.
- `data_gnt_o` out 1: request accepted this cycle.
- `data_rvalid_o` out 1: response valid.
- `data_err_o` out 1: response is an error (valid only with rvalid).
- `data_rdata_o` out 32: read data.
- `sram_csb0_o` out 1: chip select, active low.
- `sram_web0_o` out 1: write enable, active low.
- `sram_wmask0_o` out 4: write mask.
- `sram_addr0_o` out ADDR_WIDTH: word address.
- `sram_din0_o` out 32: write data.
- `sram_dout0_i` in 32: read data, valid in the cycle after the access edge.

## Operation
- Decode: `hit` = data_addr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]. SRAM word address = data_addr_i[ADDR_WIDTH+1:2]; addr[1:0] are ignored.
- FSM states: IDLE, WAIT.
  - IDLE: if req and WAIT_STATES==0, grant combinationally this cycle and stay in IDLE. If req and WAIT_STATES>0, load counter = WAIT_STATES−1 and go to WAIT (no grant).
  - WAIT: if req drops, return to IDLE without grant or response. Otherwise, when counter==0, grant and return to IDLE; else decrement the counter.
- Grant cycle, hit: csb0=0; web0=~we; wmask0=be (writes) or 4'h0 (reads); addr0/din0 taken from the request.
- Grant cycle, miss: no SRAM access; the error flag is recorded.
- All other cycles: csb0=1, web0=1, wmask0/addr0/din0 = 0.
- Response register, loaded on every grant edge with {valid, we, err}:
  - rvalid=1 in the cycle after the grant, for exactly one cycle.
  - err = registered miss flag.
  - rdata = sram_dout0_i for a hit read; 0 for writes, errors, and whenever rvalid=0.
- A write with be=0 in-window is still granted and accessed with wmask 0; memory is unchanged and the response has err=0.
- Request fields must stay stable from req assertion until grant (core protocol). The bridge does not re-latch them before grant.

## Timing
- Reset values: gnt=0, rvalid=0, err=0, rdata=0, csb0=1, web0=1, wmask0/addr0/din0=0, FSM=IDLE, counter=0.
- Request asserted in cycle R: grant in cycle R+WAIT_STATES, rvalid in cycle R+WAIT_STATES+1.
- Throughput:
  - WAIT_STATES=0: one access per cycle. The rvalid of access N and the gnt of access N+1 coincide.
  - WAIT_STATES=W>0: one access per W+1 cycles. Counting for the next request starts in the cycle after the previous grant; that cycle is in IDLE.
- The response is never stalled; the core always accepts rvalid.
- Reset asserted mid-operation: all outputs return to reset values asynchronously. A pending response is discarded (no rvalid after reset release). An SRAM access whose grant edge coincides with reset assertion is not guaranteed.
- Release of resetn is synchronised externally; the first grant is possible in the first cycle after release.

## Test plan
- Hit read, W=0: preload word 5 = 32'hDEAD_BEEF; req read at addr 0x14 → gnt same cycle with csb0=0, web0=1, addr0=5; next cycle rvalid=1, err=0, rdata=32'hDEAD_BEEF.
- Byte-masked write then read, W=0:
  - Write 32'h1122_3344 at 0x20 with be=4'hF.
  - Write 32'hAAxx_xxBB-style data 32'hAA00_00BB with be=4'b1001.
  - Read 0x20 → rdata=32'hAA22_33BB; both writes respond with rvalid, err=0, rdata=0.
- Out of window, BASE_ADDR=0, ADDR_WIDTH=8: read at 0x400 → gnt, csb0 stays 1; next cycle rvalid=1, err=1, rdata=0.
- Back-to-back, W=0: req held for 4 reads at 0x0, 0x4, 0x8, 0xC → 4 consecutive gnts, then 4 consecutive rvalids starting one cycle later, each carrying the matching data.
- Wait states, W=2:
  - Req in cycle 0 → gnt in cycle 2, rvalid in cycle 3.
  - Req held for a second access → next gnt in cycle 5.
  - Req dropped in cycle 1 → no gnt, no rvalid, FSM back in IDLE.
- Reset mid-operation: assert resetn=0 in the cycle after a grant → rvalid stays 0, csb0=1 immediately. After release, a new read completes normally.
